// File: rtl/money_disp_pkg.sv
// Shared constants for the money display: 7-segment codes {A..G}, digit count, index width
// and a helper that splits a 0..31 credit into tens and ones.
package money_disp_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int IDX_W      = 3;

  typedef logic [IDX_W-1:0] dig_idx_t;

  typedef struct packed {
    logic [1:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  localparam logic [6:0] SEG_CODE_0 = 7'b1111110;
  localparam logic [6:0] SEG_CODE_1 = 7'b0110000;
  localparam logic [6:0] SEG_CODE_2 = 7'b1101101;
  localparam logic [6:0] SEG_CODE_3 = 7'b1111001;
  localparam logic [6:0] SEG_CODE_4 = 7'b0110011;
  localparam logic [6:0] SEG_CODE_5 = 7'b1011011;
  localparam logic [6:0] SEG_CODE_6 = 7'b1011111;
  localparam logic [6:0] SEG_CODE_7 = 7'b1110010;
  localparam logic [6:0] SEG_CODE_8 = 7'b1111111;
  localparam logic [6:0] SEG_CODE_9 = 7'b1111011;
  localparam logic [6:0] SEG_BLANK  = 7'b0000000;

  // Credit never exceeds 31, so three compares replace a real divider.
  function automatic bcd2_t split_money(input logic [4:0] v);
    bcd2_t b;
    if (v >= 5'd30) begin
      b.tens = 2'd3;
      b.ones = 4'(v - 5'd30);
    end else if (v >= 5'd20) begin
      b.tens = 2'd2;
      b.ones = 4'(v - 5'd20);
    end else if (v >= 5'd10) begin
      b.tens = 2'd1;
      b.ones = 4'(v - 5'd10);
    end else begin
      b.tens = 2'd0;
      b.ones = v[3:0];
    end
    return b;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD-plus-blank to 7-segment {A..G} decoder, active-high segments.
// Codes 10..15 decode to blank so stray values never light a pattern.
module seg7_decode
  import money_disp_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    seg = SEG_CODE_0;
        4'd1:    seg = SEG_CODE_1;
        4'd2:    seg = SEG_CODE_2;
        4'd3:    seg = SEG_CODE_3;
        4'd4:    seg = SEG_CODE_4;
        4'd5:    seg = SEG_CODE_5;
        4'd6:    seg = SEG_CODE_6;
        4'd7:    seg = SEG_CODE_7;
        4'd8:    seg = SEG_CODE_8;
        4'd9:    seg = SEG_CODE_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/money_disp_scan.sv
// Six-digit multiplexed scan of the credit value (0..31, decimal, leading zero suppressed).
// Tear-free per-frame snapshot; BUSY blinking only when MONEY_DISP_BLINK_EN is defined.
module money_disp_scan
  import money_disp_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int DEAD_CYC     = 16,
  parameter int BLINK_FRAMES = 40
) (
  input  logic       CLK,
  input  logic       RSTB,
  input  logic [4:0] MONEY,
  input  logic       BUSY,
  output logic [5:0] DIGIT,
  output logic [6:0] SEG,
  output logic       SEG_DP
);

  localparam int CNT_W = $clog2(SCAN_DIV);

  logic [CNT_W-1:0] slot_cnt, slot_cnt_nxt;
  dig_idx_t         dig_idx, dig_idx_nxt;
  logic             slot_end, frame_end;

  logic [4:0] money_s1, money_s2;
  logic [4:0] snap, snap_nxt;
  logic       first_ld;
  logic       hid_nxt;

  bcd2_t            bcd;
  logic [3:0]       dec_bcd;
  logic             dec_blank;
  logic [6:0]       dec_seg;
  logic             vis;
  logic [NUM_DIGITS-1:0] one_hot;

  assign slot_end  = (slot_cnt == CNT_W'(SCAN_DIV - 1));
  assign frame_end = slot_end && (dig_idx == dig_idx_t'(NUM_DIGITS - 1));

  always_comb begin
    slot_cnt_nxt = slot_end ? '0 : slot_cnt + CNT_W'(1);
    dig_idx_nxt  = dig_idx;
    if (frame_end)
      dig_idx_nxt = '0;
    else if (slot_end)
      dig_idx_nxt = dig_idx + dig_idx_t'(1);
  end

  // Synchronizer runs without reset so it already holds MONEY when RSTB releases,
  // letting the post-reset snapshot load on the very first edge.
  always_ff @(posedge CLK) begin
    money_s1 <= MONEY;
    money_s2 <= money_s1;
  end

  assign snap_nxt = (first_ld || frame_end) ? money_s2 : snap;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      slot_cnt <= '0;
      dig_idx  <= '0;
      snap     <= '0;
      first_ld <= 1'b1;
    end else begin
      slot_cnt <= slot_cnt_nxt;
      dig_idx  <= dig_idx_nxt;
      snap     <= snap_nxt;
      first_ld <= 1'b0;
    end
  end

`ifdef MONEY_DISP_BLINK_EN
  localparam int BF_W = $clog2(BLINK_FRAMES + 1);

  logic            busy_s1, busy_s2;
  logic [BF_W-1:0] blink_cnt, blink_cnt_nxt;
  logic            blink_hid;

  always_ff @(posedge CLK) begin
    busy_s1 <= BUSY;
    busy_s2 <= busy_s1;
  end

  // Visibility only changes at frame boundaries, so a frame is either fully lit or fully dark.
  always_comb begin
    blink_cnt_nxt = blink_cnt;
    hid_nxt       = blink_hid;
    if (frame_end) begin
      if (!busy_s2) begin
        blink_cnt_nxt = '0;
        hid_nxt       = 1'b0;
      end else if (blink_cnt == BF_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_nxt = '0;
        hid_nxt       = ~blink_hid;
      end else begin
        blink_cnt_nxt = blink_cnt + BF_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      blink_cnt <= '0;
      blink_hid <= 1'b0;
    end else begin
      blink_cnt <= blink_cnt_nxt;
      blink_hid <= hid_nxt;
    end
  end
`else
  logic unused_busy;
  assign unused_busy = BUSY;
  assign hid_nxt     = 1'b0;
`endif

  // Outputs are decoded from next-state so DIGIT/SEG line up with the slot counter.
  assign bcd = split_money(snap_nxt);

  always_comb begin
    dec_bcd   = '0;
    dec_blank = 1'b1;
    case (dig_idx_nxt)
      dig_idx_t'(0): begin
        dec_bcd   = bcd.ones;
        dec_blank = 1'b0;
      end
      dig_idx_t'(1): begin
        dec_bcd   = {2'b00, bcd.tens};
        dec_blank = (bcd.tens == 2'd0);
      end
      default: begin
        dec_bcd   = '0;
        dec_blank = 1'b1;
      end
    endcase
  end

  seg7_decode u_seg7_decode (
    .bcd   (dec_bcd),
    .blank (dec_blank),
    .seg   (dec_seg)
  );

  assign vis     = (slot_cnt_nxt >= CNT_W'(DEAD_CYC)) && !hid_nxt;
  assign one_hot = NUM_DIGITS'(1) << dig_idx_nxt;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      DIGIT <= '0;
      SEG   <= SEG_BLANK;
    end else begin
      DIGIT <= vis ? one_hot : '0;
      SEG   <= vis ? dec_seg : SEG_BLANK;
    end
  end

  assign SEG_DP = 1'b0;

endmodule

// File: tb/tb_money_disp_scan.sv
// Directed bench for money_disp_scan with SCAN_DIV=8, DEAD_CYC=2, BLINK_FRAMES=2,
// followed by a random MONEY/RSTB run that watches DIGIT for multi-hot.
module tb_money_disp_scan;

  localparam logic [6:0] SB = 7'b0000000;
  localparam logic [6:0] S0 = 7'b1111110;
  localparam logic [6:0] S1 = 7'b0110000;
  localparam logic [6:0] S2 = 7'b1101101;
  localparam logic [6:0] S3 = 7'b1111001;
  localparam logic [6:0] S5 = 7'b1011011;
  localparam logic [6:0] S7 = 7'b1110010;
  localparam logic [6:0] S9 = 7'b1111011;

`ifdef MONEY_DISP_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic       CLK;
  logic       RSTB;
  logic [4:0] MONEY;
  logic       BUSY;
  logic [5:0] DIGIT;
  logic [6:0] SEG;
  logic       SEG_DP;

  int n_chk;
  int n_err;
  int frame_no;

  money_disp_scan #(
    .SCAN_DIV     (8),
    .DEAD_CYC     (2),
    .BLINK_FRAMES (2)
  ) dut (
    .CLK    (CLK),
    .RSTB   (RSTB),
    .MONEY  (MONEY),
    .BUSY   (BUSY),
    .DIGIT  (DIGIT),
    .SEG    (SEG),
    .SEG_DP (SEG_DP)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Called at a negedge where the slot counter is 0 and the index is 0; checks one
  // whole frame (48 cycles) and optionally changes MONEY/BUSY right after cycle chg_k.
  task automatic run_frame(input logic [6:0] s1, input logic [6:0] s0, input bit hid,
                           input int chg_k, input logic [4:0] nm, input logic nb);
    logic [5:0] ed;
    logic [6:0] es;
    int c;
    int i;
    for (int k = 1; k <= 48; k++) begin
      tick();
      c = k % 8;
      i = k / 8;
      if (c >= 2 && !hid) begin
        ed = 6'b000001 << i;
        es = (i == 0) ? s0 : (i == 1) ? s1 : SB;
      end else begin
        ed = '0;
        es = SB;
      end
      chk($sformatf("f%0d k%0d digit", frame_no, k), 32'(DIGIT), 32'(ed));
      chk($sformatf("f%0d k%0d seg", frame_no, k), 32'(SEG), 32'(es));
      if (k == chg_k) begin
        MONEY = nm;
        BUSY  = nb;
      end
    end
    frame_no++;
  endtask

  initial begin
    n_chk    = 0;
    n_err    = 0;
    frame_no = 0;
    RSTB     = 1'b0;
    MONEY    = 5'd5;
    BUSY     = 1'b0;

    repeat (4) @(negedge CLK);
    chk("reset digit", 32'(DIGIT), 32'h0);
    chk("reset seg", 32'(SEG), 32'(SB));
    chk("reset dp", 32'(SEG_DP), 32'h0);

    RSTB = 1'b1;
    chk("release digit", 32'(DIGIT), 32'h0);

    // Scan order with a single digit, then two-digit values and digit changes.
    run_frame(SB, S5, 1'b0, -1, 5'd5, 1'b0);
    run_frame(SB, S5, 1'b0, 10, 5'd23, 1'b0);
    run_frame(S2, S3, 1'b0, 20, 5'd10, 1'b0);
    run_frame(S1, S0, 1'b0, 5, 5'd7, 1'b0);
    // Change at index 3 must not tear the frame in progress.
    run_frame(SB, S7, 1'b0, 28, 5'd31, 1'b0);
    run_frame(S3, S1, 1'b0, 40, 5'd0, 1'b0);
    // Latest change that still makes the next frame (2 sync cycles before wrap).
    run_frame(SB, S0, 1'b0, 45, 5'd30, 1'b0);
    run_frame(S3, S0, 1'b0, 10, 5'd9, 1'b0);

    // BUSY blink: 2 frames visible, 2 hidden; with the feature absent all stay visible.
    BUSY = 1'b1;
    run_frame(SB, S9, 1'b0, -1, 5'd9, 1'b1);
    run_frame(SB, S9, 1'b0, -1, 5'd9, 1'b1);
    run_frame(SB, S9, BLINK, -1, 5'd9, 1'b1);
    run_frame(SB, S9, BLINK, -1, 5'd9, 1'b1);
    run_frame(SB, S9, 1'b0, -1, 5'd9, 1'b1);
    run_frame(SB, S9, 1'b0, -1, 5'd9, 1'b1);
    run_frame(SB, S9, BLINK, 20, 5'd9, 1'b0);
    run_frame(SB, S9, 1'b0, -1, 5'd9, 1'b0);

    // Asynchronous reset in the middle of a lit slot (index 2).
    repeat (20) tick();
    chk("pre-reset digit", 32'(DIGIT), 32'h04);
    #1 RSTB = 1'b0;
    #1;
    chk("async reset digit", 32'(DIGIT), 32'h0);
    chk("async reset seg", 32'(SEG), 32'(SB));
    chk("async reset dp", 32'(SEG_DP), 32'h0);
    MONEY = 5'd12;
    repeat (3) @(negedge CLK);
    RSTB = 1'b1;
    chk("re-release digit", 32'(DIGIT), 32'h0);
    run_frame(S1, S2, 1'b0, -1, 5'd12, 1'b0);

    // Random MONEY, BUSY and reset pulses: DIGIT must never be multi-hot.
    for (int n = 0; n < 10000; n++) begin
      @(negedge CLK);
      MONEY = 5'($urandom_range(0, 31));
      BUSY  = 1'($urandom_range(0, 1));
      if (RSTB && $urandom_range(0, 299) == 0)
        RSTB = 1'b0;
      else if (!RSTB && $urandom_range(0, 2) == 0)
        RSTB = 1'b1;
      #1;
      chk("onehot", 32'($countones(DIGIT) <= 1), 32'h1);
    end
    RSTB = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
